// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// Provides the fetch queue entry layout, the PC increment and a count-width helper.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam int unsigned PC_STEP    = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

   // Bits needed to hold a count in 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous reset, a one-cycle flush and an occupancy count.
// Ports: clk, reset, clear, push/push_data, pop/pop_data (zero when empty), count.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic [cnt_width(DEPTH)-1:0]    count
);

   localparam int unsigned CW = cnt_width(DEPTH);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full queue still accepts a push when the head leaves the same cycle.
   assign do_push = push & (~full | do_pop);

   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (reset)
      !(push && full && !pop && !clear)
   );

endmodule

// File: rtl/instr_fetch_queue.sv
// Pipelined instruction fetch: PC generation, credit-limited memory requests and a prefetch queue.
// Ports: clk/reset, redirect_*, imem_req_* / imem_rsp_* to memory, instr_* valid/ready to decode.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_data
);

   // Stale tags from flushed fetches share the tag queue with live ones,
   // so it holds two windows' worth; issue also stops if it ever fills.
   localparam int unsigned TAGS = 2 * DEPTH;
   localparam int unsigned QW   = cnt_width(DEPTH);
   localparam int unsigned IW   = cnt_width(TAGS);

   logic [XLEN-1:0] fetch_pc;
   logic [QW-1:0]   q_count;
   logic [IW-1:0]   inflight;
   logic [IW-1:0]   inflight_nxt;
   logic [IW-1:0]   discard;
   logic [IW-1:0]   live;
   logic [IW:0]     used;
   logic [XLEN-1:0] tag_head;
   logic            issue_ok;
   logic            req_fire;
   logic            stale;
   logic            keep;
   fetch_entry_t    ent_in;
   fetch_entry_t    ent_out;

   assign live     = inflight - discard;
   assign used     = {1'b0, live} + (IW+1)'(q_count);
   assign issue_ok = !redirect_valid
                   && (used < (IW+1)'(DEPTH))
                   && (inflight < IW'(TAGS));
   assign req_fire = issue_ok & imem_req_ready;
   assign stale    = (discard != '0);
   assign keep     = imem_rsp_valid & ~stale & ~redirect_valid;

   assign inflight_nxt = inflight + IW'(req_fire) - IW'(imem_rsp_valid);

   assign imem_req_valid = issue_ok;
   assign imem_req_addr  = fetch_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
   end

   // On redirect everything still outstanding becomes stale.
   always_ff @(posedge clk) begin
      if (reset) begin
         discard <= '0;
      end else if (redirect_valid) begin
         discard <= inflight_nxt;
      end else if (imem_rsp_valid && stale) begin
         discard <= discard - IW'(1);
      end
   end

   assign ent_in.pc    = tag_head;
   assign ent_in.instr = imem_rsp_data;

   // Tag queue: its occupancy is the in-flight request count.
   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (TAGS)
   ) u_pc_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (1'b0),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (imem_rsp_valid),
      .pop_data  (tag_head),
      .count     (inflight)
   );

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_out_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_valid),
      .push      (keep),
      .push_data (ent_in),
      .pop       (instr_ready),
      .pop_data  (ent_out),
      .count     (q_count)
   );

   assign instr_valid = (q_count != '0);
   assign instr_pc    = ent_out.pc;
   assign instr_data  = ent_out.instr;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency in-order memory model.
// Cycle table for streaming/redirect/wrap, plus sequences for backpressure, flushes and reset.
module tb_instr_fetch_queue;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;

   instr_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_pc       (instr_pc),
      .instr_data     (instr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        e_qv;
      logic [31:0] e_qa;
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_data;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int lat   = 1;
   int cyc   = 0;
   int fires = 0;
   int rsp_cnt = 0;

   mreq_t       mq[$];
   logic [31:0] dv_pc[$];
   logic [31:0] dv_data[$];

   logic        o_rv;
   logic [31:0] o_ra;
   logic        o_iv;
   logic [31:0] o_pc;
   logic [31:0] o_data;

   vec_t tv[13];

   function automatic logic [31:0] img(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle; entered and left at a falling edge.
   task automatic tick();
      mreq_t       r;
      logic        fire;
      logic [31:0] fa;
      if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = img(mq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      o_rv   = imem_req_valid;
      o_ra   = imem_req_addr;
      o_iv   = instr_valid;
      o_pc   = instr_pc;
      o_data = instr_data;
      fire   = !reset && imem_req_valid && imem_req_ready;
      fa     = imem_req_addr;
      if (!reset && o_iv && instr_ready && !redirect_valid) begin
         dv_pc.push_back(o_pc);
         dv_data.push_back(o_data);
      end
      @(posedge clk);
      if (reset) begin
         mq.delete();
      end else begin
         if (imem_rsp_valid) begin
            r = mq.pop_front();
            rsp_cnt++;
         end
         if (fire) begin
            fires++;
            r.addr = fa;
            r.due  = cyc + lat;
            mq.push_back(r);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      tick();
      reset   = 1'b0;
      cyc     = 0;
      fires   = 0;
      rsp_cnt = 0;
      dv_pc.delete();
      dv_data.delete();
   endtask

   task automatic chk_seq(input string name, input logic [31:0] start,
                          input int min_n);
      int bad;
      bad = 0;
      for (int i = 0; i < dv_pc.size(); i++) begin
         if (dv_pc[i] !== start + 32'(4 * i)) bad++;
         if (dv_data[i] !== img(dv_pc[i])) bad++;
      end
      chk({name, "_bad"}, 32'(bad), 32'd0);
      chk({name, "_enough"}, 32'(dv_pc.size() >= min_n), 32'd1);
      if (dv_pc.size() > 0) begin
         chk({name, "_first_pc"}, dv_pc[0], start);
         chk({name, "_first_data"}, dv_data[0], img(start));
      end else begin
         chk({name, "_first_pc"}, 32'hDEAD_BEEF, start);
      end
   endtask

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      instr_ready    = 1'b1;

      tv[0]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
      tv[1]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0,         32'h0};
      tv[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'hC0DE_0000};
      tv[3]  = '{1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'hC0DE_0004};
      tv[4]  = '{1'b1, 32'h0000_0103, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'hC0DE_0008};
      tv[5]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0};
      tv[6]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'h0};
      tv[7]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'hC0DE_0100};
      tv[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104, 32'hC0DE_0104};
      tv[9]  = '{1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
      tv[10] = '{1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
      tv[11] = '{1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC};
      tv[12] = '{1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'hC0DE_0000};

      @(negedge clk);

      // Streaming, redirect with misaligned target, PC wrap (zero-wait memory).
      lat = 1;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         redirect_valid = tv[i].rv;
         redirect_pc    = tv[i].rpc;
         tick();
         chk($sformatf("t%0d_req_valid", i), 32'(o_rv), 32'(tv[i].e_qv));
         chk($sformatf("t%0d_req_addr", i), o_ra, tv[i].e_qa);
         chk($sformatf("t%0d_instr_valid", i), 32'(o_iv), 32'(tv[i].e_iv));
         chk($sformatf("t%0d_instr_pc", i), o_pc, tv[i].e_pc);
         chk($sformatf("t%0d_instr_data", i), o_data, tv[i].e_data);
      end
      redirect_valid = 1'b0;

      // Decode stalled: exactly DEPTH requests, then resume after first pop.
      do_reset();
      instr_ready = 1'b0;
      repeat (8) tick();
      chk("bp_fires", 32'(fires), 32'd4);
      chk("bp_req_valid_low", 32'(o_rv), 32'd0);
      chk("bp_head_pc", o_pc, 32'h0);
      instr_ready = 1'b1;
      tick();
      chk("bp_pop_valid", 32'(o_iv), 32'd1);
      chk("bp_pop_req_valid", 32'(o_rv), 32'd0);
      tick();
      chk("bp_resume_valid", 32'(o_rv), 32'd1);
      chk("bp_resume_addr", o_ra, 32'h0000_0010);
      chk("bp_next_pc", o_pc, 32'h0000_0004);

      // Three-cycle memory, three in flight, redirect to 0x100.
      lat = 3;
      do_reset();
      repeat (3) tick();
      chk("lat_fires", 32'(fires), 32'd3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      chk("lat_dropped", 32'(rsp_cnt), 32'd3);
      chk("lat_none_early", 32'(dv_pc.size()), 32'd0);
      repeat (12) tick();
      chk_seq("lat", 32'h0000_0100, 5);

      // Redirect with a same-cycle response, then a second redirect.
      do_reset();
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      tick();
      redirect_valid = 1'b0;
      repeat (15) tick();
      chk_seq("dbl", 32'h0000_0300, 5);
      chk("dbl_discard", 32'(dut.discard), 32'd0);

      // Reset with a full prefetch queue.
      lat = 1;
      do_reset();
      instr_ready = 1'b0;
      repeat (8) tick();
      chk("rst_full_valid", 32'(o_iv), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("rst_instr_valid", 32'(o_iv), 32'd0);
      chk("rst_req_valid", 32'(o_rv), 32'd1);
      chk("rst_req_addr", o_ra, 32'h0000_0000);
      chk("rst_instr_pc", o_pc, 32'h0);
      chk("rst_instr_data", o_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
